// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: ping-pong direction
// encodings, the initial one-hot pattern and the default tick periods.
package led_pattern_pkg;

  localparam logic [0:0] DIR_LEFT  = 1'b0;
  localparam logic [0:0] DIR_RIGHT = 1'b1;

  // Low bit set; the top level sizes this to its pattern width.
  localparam int unsigned PATTERN_INIT = 1;

  localparam int unsigned DEFAULT_LIMIT_R0 = 50000000;
  localparam int unsigned DEFAULT_LIMIT_R1 = 25000000;
  localparam int unsigned DEFAULT_LIMIT_R2 = 12500000;
  localparam int unsigned DEFAULT_LIMIT_R3 = 6250000;

  // A period of zero clocks is meaningless; treat it as one tick per clock.
  function automatic int unsigned clamp_limit(input int unsigned limit);
    return (limit == 0) ? 1 : limit;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Rate-selectable prescaler: counts enabled clocks and fires a one-cycle tick
// once the selected period has elapsed.
module led_prescaler
  import led_pattern_pkg::*;
#(
  parameter int          NB_SEL     = 2,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_R0   = DEFAULT_LIMIT_R0,
  parameter int unsigned LIMIT_R1   = DEFAULT_LIMIT_R1,
  parameter int unsigned LIMIT_R2   = DEFAULT_LIMIT_R2,
  parameter int unsigned LIMIT_R3   = DEFAULT_LIMIT_R3
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_SEL-1:0] i_sel,
  output logic              o_advance,
  output logic              o_tick
);

  localparam logic [NB_COUNTER-1:0] LIM0 = NB_COUNTER'(clamp_limit(LIMIT_R0));
  localparam logic [NB_COUNTER-1:0] LIM1 = NB_COUNTER'(clamp_limit(LIMIT_R1));
  localparam logic [NB_COUNTER-1:0] LIM2 = NB_COUNTER'(clamp_limit(LIMIT_R2));
  localparam logic [NB_COUNTER-1:0] LIM3 = NB_COUNTER'(clamp_limit(LIMIT_R3));

  logic [NB_COUNTER-1:0] count_q;
  logic [NB_COUNTER-1:0] limit;
  logic [NB_COUNTER-1:0] limit_m1;

  always_comb begin
    limit = LIM0;
    if (i_sel == NB_SEL'(1)) limit = LIM1;
    if (i_sel == NB_SEL'(2)) limit = LIM2;
    if (i_sel == NB_SEL'(3)) limit = LIM3;
    limit_m1 = limit - NB_COUNTER'(1);
  end

  // >= rather than == so a switch to a shorter period mid-count fires at once.
  assign o_advance = i_enable && (count_q >= limit_m1);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      count_q <= '0;
      o_tick  <= 1'b0;
    end else if (i_enable) begin
      if (o_advance) begin
        count_q <= '0;
        o_tick  <= 1'b1;
      end else begin
        count_q <= count_q + NB_COUNTER'(1);
        o_tick  <= 1'b0;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED animation source: flash, rotating one-hot and ping-pong one-hot
// patterns, all advancing together on the prescaler tick.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int          NB_LED     = 4,
  parameter int          NB_SEL     = 2,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_R0   = DEFAULT_LIMIT_R0,
  parameter int unsigned LIMIT_R1   = DEFAULT_LIMIT_R1,
  parameter int unsigned LIMIT_R2   = DEFAULT_LIMIT_R2,
  parameter int unsigned LIMIT_R3   = DEFAULT_LIMIT_R3
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_SEL-1:0] i_sel,
  output logic [NB_LED-1:0] o_led_flash,
  output logic [NB_LED-1:0] o_led_shiftreg,
  output logic [NB_LED-1:0] o_led_shift_mode,
  output logic              o_tick
);

  localparam logic [NB_LED-1:0] INIT = NB_LED'(PATTERN_INIT);

  logic              advance;
  logic [NB_LED-1:0] flash_q;
  logic [NB_LED-1:0] shiftreg_q;
  logic [NB_LED-1:0] mode_q;
  logic [0:0]        dir_q;

  function automatic logic is_onehot(input logic [NB_LED-1:0] v);
    return (v != '0) && ((v & (v - NB_LED'(1))) == '0);
  endfunction

  led_prescaler #(
    .NB_SEL     (NB_SEL),
    .NB_COUNTER (NB_COUNTER),
    .LIMIT_R0   (LIMIT_R0),
    .LIMIT_R1   (LIMIT_R1),
    .LIMIT_R2   (LIMIT_R2),
    .LIMIT_R3   (LIMIT_R3)
  ) u_prescaler (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_sel     (i_sel),
    .o_advance (advance),
    .o_tick    (o_tick)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      flash_q    <= '0;
      shiftreg_q <= INIT;
    end else if (advance) begin
      flash_q <= ~flash_q;
      // A corrupted rotate pattern would never recover by itself; reload it.
      if (!is_onehot(shiftreg_q))
        shiftreg_q <= INIT;
      else
        shiftreg_q <= {shiftreg_q[NB_LED-2:0], shiftreg_q[NB_LED-1]};
    end
  end

  // Ping-pong: bounce off either end without dwelling on the end LED.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q <= INIT;
      dir_q  <= DIR_LEFT;
    end else if (advance) begin
      if (!is_onehot(mode_q)) begin
        mode_q <= INIT;
        dir_q  <= DIR_LEFT;
      end else if (dir_q == DIR_LEFT) begin
        if (mode_q[NB_LED-1]) begin
          dir_q  <= DIR_RIGHT;
          mode_q <= mode_q >> 1;
        end else begin
          mode_q <= mode_q << 1;
        end
      end else begin
        if (mode_q[0]) begin
          dir_q  <= DIR_LEFT;
          mode_q <= mode_q << 1;
        end else begin
          mode_q <= mode_q >> 1;
        end
      end
    end
  end

  assign o_led_flash      = flash_q;
  assign o_led_shiftreg   = shiftreg_q;
  assign o_led_shift_mode = mode_q;

endmodule
